// File: rtl/hazard_forward_pipe.sv
// Hazard detection and operand forwarding for an in-order pipeline.
// It tracks DEPTH stages after decode and drives the register-file writeback from the oldest stage.
module hazard_forward_pipe #(
   parameter int DATA_WIDTH         = 64,
   parameter int REG_ADDRESS_LENGTH = 5,
   parameter int DEPTH              = 3,
   parameter int LOAD_STAGE         = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          id_valid,
   input  logic [REG_ADDRESS_LENGTH-1:0] id_rs_a,
   input  logic [REG_ADDRESS_LENGTH-1:0] id_rs_b,
   input  logic                          id_use_a,
   input  logic                          id_use_b,
   input  logic [REG_ADDRESS_LENGTH-1:0] id_rd,
   input  logic                          id_wr_en,
   input  logic                          id_is_load,
   input  logic                          flush,
   input  logic [DATA_WIDTH-1:0]         ex_result,
   input  logic [DATA_WIDTH-1:0]         mem_data,
   output logic                          fwd_hit_a,
   output logic                          fwd_hit_b,
   output logic [DATA_WIDTH-1:0]         fwd_data_a,
   output logic [DATA_WIDTH-1:0]         fwd_data_b,
   output logic                          stall,
   output logic                          wb_en,
   output logic [REG_ADDRESS_LENGTH-1:0] wb_rd,
   output logic [DATA_WIDTH-1:0]         wb_data,
   output logic [15:0]                   stall_cycles
);

   typedef struct packed {
      logic                  hit;
      logic                  blocked;
      logic [DATA_WIDTH-1:0] data;
   } fwd_t;

   logic [DEPTH:1]                v;
   logic [DEPTH:1]                wr_en;
   logic [DEPTH:1]                is_load;
   logic [REG_ADDRESS_LENGTH-1:0] rd   [1:DEPTH];
   logic [DATA_WIDTH-1:0]         data [1:DEPTH];

   fwd_t res_a;
   fwd_t res_b;
   logic issue;

   // Youngest matching writer decides; an older writer behind it is ignored.
   function automatic fwd_t lookup(input logic [REG_ADDRESS_LENGTH-1:0] rs);
      fwd_t r;
      logic found;
      r     = '0;
      found = 1'b0;
      for (int s = 1; s <= DEPTH; s++) begin
         if (!found && v[s] && wr_en[s] && rd[s] == rs && rs != '0) begin
            found = 1'b1;
            if (s == 1 && !is_load[s]) begin
               r.hit  = 1'b1;
               r.data = ex_result;
            end else if (is_load[s] && s < LOAD_STAGE) begin
               r.blocked = 1'b1;
            end else if (is_load[s] && s == LOAD_STAGE) begin
               r.hit  = 1'b1;
               r.data = mem_data;
            end else begin
               r.hit  = 1'b1;
               r.data = data[s];
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      res_a = lookup(id_rs_a);
      res_b = lookup(id_rs_b);
      stall = id_valid && !flush &&
              ((id_use_a && res_a.blocked) || (id_use_b && res_b.blocked));
      issue = id_valid && !stall && !flush;
   end

   assign fwd_hit_a  = res_a.hit;
   assign fwd_hit_b  = res_b.hit;
   assign fwd_data_a = res_a.data;
   assign fwd_data_b = res_b.data;

   assign wb_en   = v[DEPTH] && wr_en[DEPTH] && (rd[DEPTH] != '0);
   assign wb_rd   = rd[DEPTH];
   assign wb_data = data[DEPTH];

   // NOTE: all state here is sequential, so every assignment uses <= to avoid read/write races between stages.
   always_ff @(posedge clk) begin
      if (reset) begin
         v            <= '0;
         wr_en        <= '0;
         is_load      <= '0;
         stall_cycles <= '0;
         for (int s = 1; s <= DEPTH; s++) begin
            rd[s]   <= '0;
            data[s] <= '0;
         end
      end else begin
         v[1]       <= issue;
         wr_en[1]   <= issue && id_wr_en;
         is_load[1] <= issue && id_is_load;
         rd[1]      <= issue ? id_rd : '0;
         data[1]    <= '0;
         for (int s = 1; s < DEPTH; s++) begin
            v[s+1]       <= v[s];
            wr_en[s+1]   <= wr_en[s];
            is_load[s+1] <= is_load[s];
            rd[s+1]      <= rd[s];
            // Results enter the pipe where they are produced: ALU at stage 1, load data at LOAD_STAGE.
            if (s == 1 && !is_load[s])
               data[s+1] <= ex_result;
            else if (s == LOAD_STAGE && is_load[s])
               data[s+1] <= mem_data;
            else
               data[s+1] <= data[s];
         end
         if (stall && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_forward_pipe.sv
// Self-checking bench for hazard_forward_pipe: directed scenarios plus randomized traffic
// compared against an instruction-age reference model.
module tb_hazard_forward_pipe;

   localparam int DW = 64;
   localparam int AW = 5;
   localparam int DEPTH = 3;
   localparam int LS = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          id_valid = 1'b0;
   logic [AW-1:0] id_rs_a = '0, id_rs_b = '0, id_rd = '0;
   logic          id_use_a = 1'b0, id_use_b = 1'b0, id_wr_en = 1'b0, id_is_load = 1'b0;
   logic          flush = 1'b0;
   logic [DW-1:0] ex_result = '0, mem_data = '0;
   logic          fwd_hit_a, fwd_hit_b, stall, wb_en;
   logic [DW-1:0] fwd_data_a, fwd_data_b, wb_data;
   logic [AW-1:0] wb_rd;
   logic [15:0]   stall_cycles;

   hazard_forward_pipe #(.DATA_WIDTH(DW), .REG_ADDRESS_LENGTH(AW), .DEPTH(DEPTH), .LOAD_STAGE(LS)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
      .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd), .id_wr_en(id_wr_en),
      .id_is_load(id_is_load), .flush(flush), .ex_result(ex_result), .mem_data(mem_data),
      .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b), .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
      .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: in-flight instructions indexed by age (1 = youngest).
   typedef struct {
      bit            v;
      bit            wr;
      bit            ld;
      logic [AW-1:0] rd;
      logic [DW-1:0] val;
   } ins_t;

   ins_t pipe [1:DEPTH];
   int   model_stalls = 0;

   task automatic model_clear();
      for (int a = 1; a <= DEPTH; a++) begin
         pipe[a].v = 0; pipe[a].wr = 0; pipe[a].ld = 0; pipe[a].rd = '0; pipe[a].val = '0;
      end
      model_stalls = 0;
   endtask

   task automatic model_lookup(input logic [AW-1:0] rs, output bit hit, output bit blk,
                               output logic [DW-1:0] val);
      hit = 0; blk = 0; val = '0;
      for (int a = DEPTH; a >= 1; a--) begin
         if (pipe[a].v && pipe[a].wr && pipe[a].rd == rs && rs != 0) begin
            hit = !(pipe[a].ld && a < LS);
            blk = !hit;
            val = hit ? pipe[a].val : '0;
         end
      end
   endtask

   // One cycle: drive inputs after the edge, check against the model, then advance the model.
   task automatic step(input bit rst, input bit vld, input logic [AW-1:0] ra, input bit ua,
                       input logic [AW-1:0] rb, input bit ub, input logic [AW-1:0] rdst,
                       input bit wr, input bit ld, input bit fl,
                       input logic [DW-1:0] ex, input logic [DW-1:0] mem);
      bit hit_a, blk_a, hit_b, blk_b, exp_stall, exp_wb;
      logic [DW-1:0] val_a, val_b;
      @(posedge clk);
      #1;
      reset = rst; id_valid = vld; id_rs_a = ra; id_use_a = ua; id_rs_b = rb; id_use_b = ub;
      id_rd = rdst; id_wr_en = wr; id_is_load = ld; flush = fl; ex_result = ex; mem_data = mem;
      #3;
      // Results are produced by ALU instructions at age 1 and by loads at the load stage.
      if (!pipe[1].ld) pipe[1].val = ex;
      if (pipe[LS].ld) pipe[LS].val = mem;
      model_lookup(ra, hit_a, blk_a, val_a);
      model_lookup(rb, hit_b, blk_b, val_b);
      exp_stall = vld && !fl && ((ua && blk_a) || (ub && blk_b));
      exp_wb = pipe[DEPTH].v && pipe[DEPTH].wr && pipe[DEPTH].rd != 0;
      check("fwd_hit_a", DW'(fwd_hit_a), DW'(hit_a));
      check("fwd_data_a", fwd_data_a, val_a);
      check("fwd_hit_b", DW'(fwd_hit_b), DW'(hit_b));
      check("fwd_data_b", fwd_data_b, val_b);
      check("stall", DW'(stall), DW'(exp_stall));
      check("wb_en", DW'(wb_en), DW'(exp_wb));
      if (exp_wb) begin
         check("wb_rd", DW'(wb_rd), DW'(pipe[DEPTH].rd));
         check("wb_data", wb_data, pipe[DEPTH].val);
      end
      check("stall_cycles", DW'(stall_cycles), DW'(model_stalls));
      if (rst) begin
         model_clear();
      end else begin
         for (int a = DEPTH; a >= 2; a--) pipe[a] = pipe[a-1];
         pipe[1].v   = vld && !exp_stall && !fl;
         pipe[1].wr  = wr;
         pipe[1].ld  = ld;
         pipe[1].rd  = rdst;
         pipe[1].val = '0;
         if (exp_stall && model_stalls < 65535) model_stalls++;
      end
   endtask

   task automatic idle();
      step(0, 0, '0, 0, '0, 0, '0, 0, 0, 0, '0, '0);
   endtask

   task automatic do_reset();
      step(1, 0, '0, 0, '0, 0, '0, 0, 0, 0, '0, '0);
   endtask

   initial begin
      model_clear();
      do_reset();
      do_reset();
      idle();
      check("reset_wb_en", DW'(wb_en), 0);
      check("reset_stall_cycles", DW'(stall_cycles), 0);

      // ALU back-to-back forwarding and writeback latency.
      step(0, 1, '0, 0, '0, 0, 5'd5, 1, 0, 0, '0, '0);
      step(0, 1, 5'd5, 1, '0, 0, '0, 0, 0, 0, 64'h11, '0);
      check("alu_fwd_hit", DW'(fwd_hit_a), 1);
      check("alu_fwd_data", fwd_data_a, 64'h11);
      check("alu_no_stall", DW'(stall), 0);
      idle();
      idle();
      check("alu_wb_en", DW'(wb_en), 1);
      check("alu_wb_rd", DW'(wb_rd), 5);
      check("alu_wb_data", wb_data, 64'h11);

      // Load-use: one stall cycle, then the load data is forwarded.
      do_reset();
      step(0, 1, '0, 0, '0, 0, 5'd7, 1, 1, 0, '0, '0);
      step(0, 1, 5'd7, 1, '0, 0, '0, 0, 0, 0, '0, '0);
      check("ld_use_stall", DW'(stall), 1);
      step(0, 1, 5'd7, 1, '0, 0, '0, 0, 0, 0, '0, 64'hABCD);
      check("ld_use_fwd", fwd_data_a, 64'hABCD);
      check("ld_use_released", DW'(stall), 0);
      check("ld_use_count", DW'(stall_cycles), 1);

      // Youngest writer wins.
      do_reset();
      step(0, 1, '0, 0, '0, 0, 5'd3, 1, 0, 0, '0, '0);
      step(0, 1, '0, 0, '0, 0, 5'd3, 1, 0, 0, 64'h33, '0);
      step(0, 1, 5'd3, 1, '0, 0, '0, 0, 0, 0, 64'h22, '0);
      check("youngest_wins", fwd_data_a, 64'h22);

      // Register 0 is never forwarded nor written.
      do_reset();
      step(0, 1, '0, 0, '0, 0, 5'd0, 1, 0, 0, '0, '0);
      step(0, 1, 5'd0, 1, '0, 0, '0, 0, 0, 0, 64'h44, '0);
      check("r0_no_hit", DW'(fwd_hit_a), 0);
      idle();
      idle();
      check("r0_no_wb", DW'(wb_en), 0);

      // Flush during a load-use hazard kills the consumer without stalling.
      do_reset();
      step(0, 1, '0, 0, '0, 0, 5'd7, 1, 1, 0, '0, '0);
      step(0, 1, 5'd7, 1, '0, 0, 5'd9, 1, 0, 1, '0, '0);
      check("flush_no_stall", DW'(stall), 0);
      step(0, 0, '0, 0, '0, 0, '0, 0, 0, 0, '0, 64'h55);
      check("flush_count_held", DW'(stall_cycles), 0);
      idle();
      check("flush_load_wb", DW'(wb_en), 1);
      idle();
      check("flush_no_wb", DW'(wb_en), 0);

      // Reset drops everything in flight.
      step(0, 1, '0, 0, '0, 0, 5'd1, 1, 0, 0, 64'h1, '0);
      step(0, 1, '0, 0, '0, 0, 5'd2, 1, 0, 0, 64'h2, '0);
      step(0, 1, '0, 0, '0, 0, 5'd4, 1, 0, 0, 64'h3, '0);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         idle();
         check("reset_drop_wb", DW'(wb_en), 0);
      end
      check("reset_drop_count", DW'(stall_cycles), 0);

      // Randomized traffic over a small register set to provoke frequent hazards.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
              AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
              AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
              AW'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
              {$urandom, $urandom}, {$urandom, $urandom});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_forward_pipe.md
HAZARD_FORWARD_PIPE -- requirements
Module: hazard_forward_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the register/result data width.
REQ-002 SHALL have parameter REG_ADDRESS_LENGTH, default 5, meaning the register-address width.
REQ-003 SHALL have parameter DEPTH, default 3, legal range >=2, meaning the number of tracked stages after decode (1 = youngest, DEPTH = writeback).
REQ-004 SHALL have parameter LOAD_STAGE, default 2, legal range 1..DEPTH-1, meaning the stage whose mem_data carries that stage's load result.
REQ-005 SHALL have ports:
  - clk  input  1  clock; single clock domain.
  - reset  input  1  synchronous, active-high reset.
  - id_valid  input  1  decode holds a valid instruction.
  - id_rs_a, id_rs_b  input  REG_ADDRESS_LENGTH  source registers in decode.
  - id_use_a, id_use_b  input  1  the source is actually read.
  - id_rd  input  REG_ADDRESS_LENGTH  destination register in decode.
  - id_wr_en  input  1  decode instruction writes id_rd.
  - id_is_load  input  1  decode instruction is a load.
  - flush  input  1  kill the decode instruction this cycle.
  - ex_result  input  DATA_WIDTH  combinational ALU result of the stage-1 entry.
  - mem_data  input  DATA_WIDTH  load data of the LOAD_STAGE entry.
  - fwd_hit_a, fwd_hit_b  output  1  forwarded operand valid.
  - fwd_data_a, fwd_data_b  output  DATA_WIDTH  forwarded operand.
  - stall  output  1  hold decode and fetch this cycle.
  - wb_en  output  1  register-file write enable.
  - wb_rd  output  REG_ADDRESS_LENGTH  register-file write address.
  - wb_data  output  DATA_WIDTH  register-file write data.
  - stall_cycles  output  16  saturating stall counter.

Function
REQ-006 SHALL hold, per stage s, the registered fields v, wr_en, is_load, rd and data (data only for stages >=2).
REQ-007 SHALL advance every stage each cycle with no downstream backpressure: stage s+1 <= stage s.
REQ-008 SHALL load stage 1 with {1, id_wr_en, id_is_load, id_rd} when id_valid & !stall & !flush; otherwise it SHALL load a bubble (v=0).
REQ-009 SHALL capture stage-2 data as ex_result when the stage-1 entry is a non-load.
REQ-010 SHALL capture stage LOAD_STAGE+1 data as mem_data when the LOAD_STAGE entry is a load.
REQ-011 SHALL otherwise copy data unchanged from stage to stage.
REQ-012 SHALL treat a stage s entry as a matching writer of X when v & wr_en & rd==X & X!=0.
REQ-013 SHALL select, per source, the lowest-index matching stage among 1..DEPTH (youngest wins).
REQ-014 SHALL apply these availability rules to the selected writer:
  - non-load in stage 1: ex_result.
  - load in stage < LOAD_STAGE: unavailable.
  - load in stage LOAD_STAGE: mem_data.
  - otherwise: stored data.
REQ-015 SHALL drive fwd_hit=1 with the available data; with no match or unavailable data, fwd_hit=0 and fwd_data=0.
REQ-016 SHALL include stage DEPTH in matching, giving same-cycle write-through relative to the synchronous register-file write.
REQ-017 SHALL assert stall combinationally when id_valid & !flush & (use_a & writer_a unavailable | use_b & writer_b unavailable).
REQ-018 SHALL, when flush=1, force stall=0 and insert a bubble regardless of hazards.
REQ-019 SHALL drive wb_en = v & wr_en & (rd!=0) of stage DEPTH, with wb_rd = rd and wb_data = data combinationally from stage DEPTH.
REQ-020 SHALL increment stall_cycles on each cycle stall=1 and saturate it at 0xFFFF.
REQ-021 SHALL have a decode-to-writeback latency of exactly DEPTH cycles after issue.

Reset
REQ-022 SHALL, on reset=1 at a clk edge, clear every stage v and all stored fields to 0 and clear stall_cycles to 0, so wb_en=0 from the next cycle.
REQ-023 SHALL give reset priority over issue, flush and counting; entries in flight at reset SHALL be dropped and never written back.

Verification (DEPTH=3, LOAD_STAGE=2)
REQ-024 ALU back-to-back: issue rd=5 at cycle 0; cycle 1 ex_result=0x11, decode rs_a=5, use_a=1 -> fwd_hit_a=1, fwd_data_a=0x11, stall=0; cycle 3 -> wb_en=1, wb_rd=5, wb_data=0x11.
REQ-025 Load-use: issue load rd=7; next cycle decode uses r7 -> stall=1 for one cycle and a bubble enters stage 1; following cycle mem_data=0xABCD -> fwd_data_a=0xABCD, stall=0, stall_cycles=1.
REQ-026 Youngest wins: r3 writers in stage 1 (ex_result=0x22) and stage 2 (data=0x33) -> fwd_data_a=0x22.
REQ-027 Register 0: writer with rd=0, wr_en=1 -> fwd_hit=0 for rs=0 and wb_en=0 at writeback.
REQ-028 Flush during hazard: flush=1 while load-use hazard is present -> stall=0, stall_cycles unchanged, no wb_en 3 cycles later.
REQ-029 Reset mid-operation: three valid entries in flight, reset=1 for one cycle -> wb_en=0 for the next 3 cycles and stall_cycles=0.
